// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, issues one imem request at a time,
// holds the returned word for the core, handles redirects, stale responses and timeouts.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        misalign_pulse,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t      state, state_d;
    logic [31:0] pc, pc_d;
    logic [15:0] cnt, cnt_d;
    logic        drop, drop_d;
    logic        req_d, valid_d, misalign_d, err_d;
    logic [31:0] instr_d, inst_pc_d;
    logic [31:0] target;
    logic        redirect_ok;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    assign target      = {redirect_pc[31:2], 2'b00};
    assign redirect_ok = redirect_valid &&
                         (state == S_REQ || state == S_WAIT || state == S_HOLD);

    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state;
        pc_d       = pc;
        cnt_d      = cnt;
        drop_d     = drop;
        req_d      = imem_req;
        valid_d    = inst_valid;
        instr_d    = instruction;
        inst_pc_d  = inst_pc;
        err_d      = fetch_err;
        misalign_d = redirect_ok && (redirect_pc[1:0] != 2'b00);

        case (state)
            S_IDLE: begin
                state_d = S_REQ;
                req_d   = 1'b1;
            end
            S_REQ: begin
                if (redirect_valid) pc_d = target;
                if (imem_req && imem_gnt) begin
                    // A redirect alongside the grant means the old address is in flight.
                    state_d = S_WAIT;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    drop_d  = redirect_valid;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d   = target;
                    drop_d = 1'b1;
                end
                if (imem_rvalid) begin
                    if (drop || redirect_valid) begin
                        state_d = S_REQ;
                        req_d   = 1'b1;
                        drop_d  = 1'b0;
                    end else begin
                        state_d   = S_HOLD;
                        valid_d   = 1'b1;
                        instr_d   = imem_rdata;
                        inst_pc_d = pc;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d = S_ERR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            S_HOLD: begin
                // Redirect takes priority; the held word is treated as consumed.
                if (redirect_valid) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    pc_d    = target;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                    req_d   = 1'b1;
                    valid_d = 1'b0;
                    pc_d    = pc + 32'd4;
                end
            end
            S_ERR: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                err_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            cnt            <= '0;
            drop           <= 1'b0;
            imem_req       <= 1'b0;
            imem_addr      <= RESET_PC;
            inst_valid     <= 1'b0;
            instruction    <= '0;
            inst_pc        <= '0;
            misalign_pulse <= 1'b0;
            fetch_err      <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            cnt            <= cnt_d;
            drop           <= drop_d;
            imem_req       <= req_d;
            imem_addr      <= pc_d;
            inst_valid     <= valid_d;
            instruction    <= instr_d;
            inst_pc        <= inst_pc_d;
            misalign_pulse <= misalign_d;
            fetch_err      <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: table-driven fetches with a response scoreboard,
// plus hand-written redirect, wrap, reset and timeout sequences.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        misalign_pulse;
    logic        fetch_err;

    localparam logic [31:0] STALE = 32'hDEAD_BEEF;

    fetch_ctrl #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .misalign_pulse (misalign_pulse),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          lat;
        int          stall;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    // All tasks start and end at a falling edge; inputs change there.
    task automatic wait_req(input logic [31:0] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'd0, imem_req}, 32'd1);
        check("req_addr", imem_addr, exp_addr);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        check("req_low_in_wait", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic respond(input logic [31:0] addr, input int lat, input bit keep);
        for (int i = 1; i < lat; i++) begin
            check("valid_low_in_wait", {31'd0, inst_valid}, 32'd0);
            @(negedge clk);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = keep ? mem_word(addr) : STALE;
        if (keep) sb.push_back('{pc: addr, data: mem_word(addr)});
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    task automatic take_inst(output exp_t e);
        int n = 0;
        while (!inst_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("inst_valid_seen", {31'd0, inst_valid}, 32'd1);
        check("hold_latency", n, 0);
        if (sb.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("inst_pc", inst_pc, e.pc);
        check("instruction", instruction, e.data);
    endtask

    task automatic consume(input int stall);
        exp_t e;
        take_inst(e);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, inst_valid}, 32'd1);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_pc", inst_pc, e.pc);
            check("stall_instr", instruction, e.data);
        end
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("accept_valid_low", {31'd0, inst_valid}, 32'd0);
        check("turnaround_req", {31'd0, imem_req}, 32'd1);
        check("next_addr", imem_addr, e.pc + 32'd4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        exp_t e;

        vecs[0] = '{addr: 32'h00, lat: 1, stall: 0};
        vecs[1] = '{addr: 32'h04, lat: 1, stall: 0};
        vecs[2] = '{addr: 32'h08, lat: 1, stall: 0};
        vecs[3] = '{addr: 32'h0C, lat: 1, stall: 5};
        vecs[4] = '{addr: 32'h10, lat: 3, stall: 0};
        vecs[5] = '{addr: 32'h14, lat: 4, stall: 0};
        vecs[6] = '{addr: 32'h18, lat: 1, stall: 1};

        reset_n        = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_misalign", {31'd0, misalign_pulse}, 32'd0);
        check("rst_err", {31'd0, fetch_err}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("req_after_release", {31'd0, imem_req}, 32'd1);

        foreach (vecs[i]) begin
            wait_req(vecs[i].addr);
            respond(vecs[i].addr, vecs[i].lat, 1'b1);
            consume(vecs[i].stall);
        end

        // Redirect in WAIT; the stale response two cycles later is dropped.
        wait_req(32'h1C);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("wait_redir_misalign", {31'd0, misalign_pulse}, 32'd0);
        check("wait_redir_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        respond(32'h1C, 1, 1'b0);
        check("drop_no_valid", {31'd0, inst_valid}, 32'd0);
        check("drop_req", {31'd0, imem_req}, 32'd1);
        check("drop_addr", imem_addr, 32'h100);
        wait_req(32'h100);
        respond(32'h100, 1, 1'b1);
        consume(0);

        // Redirect to a misaligned target together with inst_ready in HOLD.
        wait_req(32'h104);
        respond(32'h104, 1, 1'b1);
        take_inst(e);
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        check("hold_redir_valid", {31'd0, inst_valid}, 32'd0);
        check("hold_redir_addr", imem_addr, 32'h200);
        check("misalign_high", {31'd0, misalign_pulse}, 32'd1);
        @(negedge clk);
        check("misalign_one_cycle", {31'd0, misalign_pulse}, 32'd0);
        wait_req(32'h200);
        respond(32'h200, 1, 1'b1);
        consume(0);

        // Redirect in REQ in the same cycle as the grant: old address is granted and dropped.
        check("req_redir_base", imem_addr, 32'h204);
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        @(negedge clk);
        imem_gnt       = 1'b0;
        redirect_valid = 1'b0;
        check("req_gnt_redir_wait", {31'd0, imem_req}, 32'd0);
        respond(32'h204, 1, 1'b0);
        check("req_gnt_drop_valid", {31'd0, inst_valid}, 32'd0);
        check("req_gnt_drop_addr", imem_addr, 32'h400);

        // Redirect in REQ without grant: address moves while still ungranted.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h502;
        @(negedge clk);
        redirect_valid = 1'b0;
        check("req_redir_addr", imem_addr, 32'h500);
        check("req_redir_misalign", {31'd0, misalign_pulse}, 32'd1);
        wait_req(32'h500);
        respond(32'h500, 1, 1'b1);
        consume(0);

        // PC wrap from the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        wait_req(32'hFFFF_FFFC);
        respond(32'hFFFF_FFFC, 1, 1'b1);
        consume(0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset during WAIT, then stale responses after release.
        wait_req(32'h0);
        reset_n = 1'b0;
        #1;
        check("midrst_req", {31'd0, imem_req}, 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        @(negedge clk);
        reset_n     = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = STALE;
        @(negedge clk);
        check("stale_idle_valid", {31'd0, inst_valid}, 32'd0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        check("stale_req_valid", {31'd0, inst_valid}, 32'd0);
        check("stale_req_addr", imem_addr, 32'h0);
        wait_req(32'h0);
        respond(32'h0, 1, 1'b1);
        consume(0);

        // Timeout: granted, no response ever returns.
        wait_req(32'h4);
        for (int i = 0; i < 4; i++) begin
            check("pre_timeout_err", {31'd0, fetch_err}, 32'd0);
            @(negedge clk);
        end
        check("timeout_err", {31'd0, fetch_err}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            redirect_valid = 1'b1;
            redirect_pc    = 32'h301;
            imem_rvalid    = 1'b1;
            imem_gnt       = 1'b1;
            @(negedge clk);
            check("err_req", {31'd0, imem_req}, 32'd0);
            check("err_sticky", {31'd0, fetch_err}, 32'd1);
            check("err_misalign", {31'd0, misalign_pulse}, 32'd0);
            check("err_valid", {31'd0, inst_valid}, 32'd0);
        end
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b0;
        imem_gnt       = 1'b0;

        reset_n = 1'b0;
        #1;
        check("rst_clears_err", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        wait_req(32'h0);
        respond(32'h0, 1, 1'b1);
        consume(0);

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequences instruction fetch for the rv32i core. It owns the PC register, issues one word request at a time to instruction memory over a req/gnt + rvalid handshake, and holds each returned instruction until the core accepts it. Taken branches and jumps arrive as redirects. The block discards stale in-flight responses and flags a timed-out memory response.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.
TIMEOUT_CYCLES, 255, max cycles in WAIT before fetch error; range 1..65535.

Ports:
clk  input  1  clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
imem_req  output  1  request valid; held high until imem_gnt.
imem_addr  output  32  word-aligned fetch address; bits [1:0] always 0.
imem_gnt  input  1  memory accepts request this cycle (qualified by imem_req).
imem_rvalid  input  1  response valid; at most one outstanding.
imem_rdata  input  32  response instruction word.
inst_valid  output  1  instruction/inst_pc valid to core.
inst_ready  input  1  core accepts instruction this cycle.
instruction  output  32  held instruction word.
inst_pc  output  32  PC of held instruction.
redirect_valid  input  1  one-cycle redirect request.
redirect_pc  input  32  redirect target.
misalign_pulse  output  1  one-cycle pulse, redirect_pc[1:0] != 0.
fetch_err  output  1  sticky timeout error; cleared only by reset.

Behaviour:
- All outputs registered. Reset (async assert, sync deassert): state IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, instruction=0, inst_pc=0, misalign_pulse=0, fetch_err=0, drop=0, timeout counter=0.
- IDLE: the first clock edge after reset release moves to REQ. imem_req goes high in cycle 1 after release.
- REQ: imem_req=1, imem_addr=pc. When imem_gnt=1, go to WAIT and clear the counter. imem_addr may change only while ungranted.
- WAIT: imem_req=0. The counter increments each cycle without imem_rvalid.
  - imem_rvalid with drop=0: capture instruction=imem_rdata and inst_pc=pc, set inst_valid=1, go to HOLD.
  - imem_rvalid with drop=1: discard the data, clear drop, go to REQ (pc already updated).
  - Counter reaches TIMEOUT_CYCLES: go to ERR.
- HOLD: inst_valid=1; instruction and inst_pc stable.
  - inst_ready=1: pc<=pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000), inst_valid<=0, go to REQ.
  - Instruction-to-request turnaround is 1 cycle; sustained throughput is one instruction per 3 cycles with zero-wait memory.
- Redirect (redirect_valid=1) by state:
  - REQ: pc<=target. imem_addr updates next cycle. If gnt is in the same cycle, the old address is granted; set drop=1 and go to WAIT.
  - WAIT: pc<=target, drop<=1. If imem_rvalid is in the same cycle, the response is discarded and the block goes straight to REQ.
  - HOLD: inst_valid<=0, pc<=target, go to REQ. Redirect wins over a simultaneous inst_ready; the held instruction counts as consumed, with no pc+4.
  - ERR or IDLE: ignored.
- Target: pc<={redirect_pc[31:2],2'b00}. misalign_pulse=1 the next cycle if redirect_pc[1:0]!=0.
- ERR: fetch_err=1, imem_req=0, inst_valid=0. Terminal until reset.
- Reset mid-transaction: outputs return to reset values immediately. Any later imem_rvalid is ignored because the state is IDLE/REQ.
- imem_rvalid outside WAIT is ignored. imem_gnt without imem_req is ignored.

Test Plan:
- Reset release, zero-wait memory (gnt same cycle, rvalid next cycle), inst_ready tied 1 -> imem_addr sequence 0x0, 0x4, 0x8. inst_valid pulses every 3 cycles; inst_pc matches.
- Core stalls with inst_ready=0 for 5 cycles in HOLD -> instruction/inst_pc constant, imem_req=0. Then ready=1 -> next request at pc+4.
- Redirect to 0x100 in WAIT, rvalid for 0x8 arrives 2 cycles later -> 0x8 data discarded, inst_valid stays 0, next imem_addr=0x100.
- Redirect to 0x203 in the same cycle as inst_ready in HOLD -> next imem_addr=0x200, misalign_pulse high for exactly one cycle, no fetch of pc+4.
- TIMEOUT_CYCLES=4, gnt given but rvalid never returns -> fetch_err=1 after 4 WAIT cycles, imem_req stays 0, later redirects ignored. Reset clears fetch_err.
- pc=0xFFFF_FFFC accepted -> next imem_addr=0x0000_0000. reset_n pulsed low during WAIT -> imem_req=0 immediately; a stale rvalid after release produces no inst_valid.
